// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared types and default widths for the main-memory arbiter
package riscv_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_e;

   typedef enum logic {
      ARB_ICACHE,
      ARB_DCACHE
   } arb_id_e;

   localparam int ARB_ADDR_W  = 64;
   localparam int ARB_LINE_W  = 128;
   localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/riscv_arb_wdt.sv
// rtl/riscv_arb_wdt.sv - busy-cycle watchdog; expire is high in the TIMEOUT-th enabled cycle
module riscv_arb_wdt
   import riscv_arb_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // count holds the number of enabled cycles already completed
   assign expire = enable && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - I/D cache arbiter for one main-memory line port
// Optional: RISCV_ARB_ROUND_ROBIN_EN selects round-robin instead of D-over-I priority.
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int LINE_W  = ARB_LINE_W,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic              i_riscv_arb_clk,
   input  logic              i_riscv_arb_rst,
   input  logic              i_riscv_arb_icache_req,
   input  logic [ADDR_W-1:0] i_riscv_arb_icache_addr,
   output logic              o_riscv_arb_icache_ack,
   output logic [LINE_W-1:0] o_riscv_arb_icache_rdata,
   input  logic              i_riscv_arb_dcache_req,
   input  logic              i_riscv_arb_dcache_we,
   input  logic [ADDR_W-1:0] i_riscv_arb_dcache_addr,
   input  logic [LINE_W-1:0] i_riscv_arb_dcache_wdata,
   output logic              o_riscv_arb_dcache_ack,
   output logic [LINE_W-1:0] o_riscv_arb_dcache_rdata,
   output logic              o_riscv_arb_mem_req,
   output logic              o_riscv_arb_mem_we,
   output logic [ADDR_W-1:0] o_riscv_arb_mem_addr,
   output logic [LINE_W-1:0] o_riscv_arb_mem_wdata,
   input  logic              i_riscv_arb_mem_ack,
   input  logic [LINE_W-1:0] i_riscv_arb_mem_rdata,
   output logic              o_riscv_arb_timeout
);

   arb_state_e state;
   arb_id_e    winner;
   logic       any_req;
   logic       grant_dcache;
   logic       wdt_clear;
   logic       wdt_enable;
   logic       wdt_expire;

   assign any_req = i_riscv_arb_icache_req | i_riscv_arb_dcache_req;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
   logic rr_icache_next;

   // on a tie the pointer picks the side that lost the previous grant
   assign grant_dcache = i_riscv_arb_dcache_req &
                         (!i_riscv_arb_icache_req | !rr_icache_next);

   always_ff @(posedge i_riscv_arb_clk) begin
      if (i_riscv_arb_rst) begin
         rr_icache_next <= 1'b1;
      end else if ((state == IDLE) && any_req) begin
         rr_icache_next <= grant_dcache;
      end
   end
`else
   assign grant_dcache = i_riscv_arb_dcache_req;
`endif

   assign wdt_enable = (state == BUSY);
   assign wdt_clear  = (state != BUSY);

   riscv_arb_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk    (i_riscv_arb_clk),
      .rst    (i_riscv_arb_rst),
      .clear  (wdt_clear),
      .enable (wdt_enable),
      .expire (wdt_expire)
   );

   always_ff @(posedge i_riscv_arb_clk) begin
      if (i_riscv_arb_rst) begin
         state                    <= IDLE;
         winner                   <= ARB_ICACHE;
         o_riscv_arb_mem_req      <= 1'b0;
         o_riscv_arb_mem_we       <= 1'b0;
         o_riscv_arb_mem_addr     <= '0;
         o_riscv_arb_mem_wdata    <= '0;
         o_riscv_arb_icache_ack   <= 1'b0;
         o_riscv_arb_dcache_ack   <= 1'b0;
         o_riscv_arb_icache_rdata <= '0;
         o_riscv_arb_dcache_rdata <= '0;
         o_riscv_arb_timeout      <= 1'b0;
      end else begin
         o_riscv_arb_icache_ack <= 1'b0;
         o_riscv_arb_dcache_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  if (grant_dcache) begin
                     winner                <= ARB_DCACHE;
                     o_riscv_arb_mem_we    <= i_riscv_arb_dcache_we;
                     o_riscv_arb_mem_addr  <= i_riscv_arb_dcache_addr;
                     o_riscv_arb_mem_wdata <= i_riscv_arb_dcache_wdata;
                  end else begin
                     winner                <= ARB_ICACHE;
                     o_riscv_arb_mem_we    <= 1'b0;
                     o_riscv_arb_mem_addr  <= i_riscv_arb_icache_addr;
                     o_riscv_arb_mem_wdata <= '0;
                  end
                  o_riscv_arb_mem_req <= 1'b1;
                  state               <= BUSY;
               end
            end
            BUSY: begin
               // a memory ack in the expiry cycle still completes normally
               if (i_riscv_arb_mem_ack) begin
                  o_riscv_arb_mem_req <= 1'b0;
                  state               <= DONE;
                  if (winner == ARB_DCACHE) begin
                     o_riscv_arb_dcache_ack <= 1'b1;
                     if (!o_riscv_arb_mem_we) begin
                        o_riscv_arb_dcache_rdata <= i_riscv_arb_mem_rdata;
                     end
                  end else begin
                     o_riscv_arb_icache_ack   <= 1'b1;
                     o_riscv_arb_icache_rdata <= i_riscv_arb_mem_rdata;
                  end
               end else if (wdt_expire) begin
                  o_riscv_arb_mem_req <= 1'b0;
                  o_riscv_arb_timeout <= 1'b1;
                  state               <= DONE;
                  if (winner == ARB_DCACHE) begin
                     o_riscv_arb_dcache_ack   <= 1'b1;
                     o_riscv_arb_dcache_rdata <= '0;
                  end else begin
                     o_riscv_arb_icache_ack   <= 1'b1;
                     o_riscv_arb_icache_rdata <= '0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
